rr_mux_n_w: RTL and testbench

//  Parametrised N-channel, WIDTH-bit registered multiplexer with round-robin arbitration.

---
 rtl/rr_mux_n_w.sv | 101 ++++++++++
 tb/tb_rr_mux_n_w.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_n_w.sv
// rr_mux_n_w -- N-channel, WIDTH-bit registered multiplexer with round-robin
// arbitration. It merges N valid/ready source streams into one registered
// output stream and grants at most one channel per cycle.
//
// Ports:
//   clk        single clock, all state updates on posedge
//   reset      synchronous, active-high; discards any held word, ptr -> N-1
//   in_data    N*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   N, channel i presents a word
//   in_ready   N, one-hot (or zero) accept strobe for the granted channel
//   out_data   WIDTH, registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer takes out_data this cycle
//   out_chan   SELW, source channel index of out_data

// Per-channel helper: the channel's position in the rotated search order,
// where position 0 is the channel right after the last grant.
module rr_mux_lane #(
  parameter int N    = 4,
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] pos
);
  // N is a power of two, so SELW-bit wrap gives the modulo-N distance.
  assign pos = SELW'(IDX) - ptr - SELW'(1);
endmodule

module rr_mux_n_w #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  logic [SELW-1:0]         ptr;      // last granted channel
  logic [N-1:0][SELW-1:0]  pos;      // rotated position of each channel
  logic [N-1:0]            req_rot;  // requests re-ordered by search order
  logic [SELW-1:0]         off;      // first requesting rotated position
  logic [SELW-1:0]         gnt;
  logic                    any_vld;
  logic                    load;
  logic                    accept;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      rr_mux_lane #(.N(N), .SELW(SELW), .IDX(gi)) u_lane (
        .ptr (ptr),
        .pos (pos[gi])
      );
    end
  endgenerate

  assign any_vld = |in_valid;
  // Register can take a word when empty or when it drains this same cycle.
  assign load    = ~out_valid | out_ready;
  assign accept  = load & any_vld & ~reset;

  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N; i++) req_rot[pos[i]] = in_valid[i];
    // Lowest rotated position wins: scan high-to-low so the last hit sticks.
    off = '0;
    for (int k = N - 1; k >= 0; k--) if (req_rot[k]) off = SELW'(k);
    gnt = ptr + SELW'(1) + off;
  end

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SELW'(N - 1);
    end else if (accept) begin
      out_data  <= in_data[int'(gnt)*WIDTH +: WIDTH];
      out_chan  <= gnt;
      out_valid <= 1'b1;
      ptr       <= gnt;
    end else if (out_ready) begin
      // Drain without refill; data/chan keep their last value.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_n_w.sv
// Testbench for rr_mux_n_w: directed scenarios followed by randomized traffic.
// A reference model predicts each grant; predicted words go into a scoreboard
// queue that a separate monitor pops whenever the DUT hands a word over.
module tb_rr_mux_n_w;
  localparam int W    = 32;
  localparam int N    = 4;
  localparam int SELW = $clog2(N);

  typedef struct {
    logic [W-1:0]    d;
    logic [SELW-1:0] c;
  } exp_t;

  logic               clk;
  logic               reset;
  logic [N*W-1:0]     in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [W-1:0]       out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_chan;

  rr_mux_n_w #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  // Source side: pending word per channel, held until accepted.
  logic         pend [N];
  logic [W-1:0] pdat [N];

  // Reference model state.
  int   m_ptr  = N - 1;
  logic m_full = 1'b0;

  logic [N-1:0] seen_rdy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, check strobes, advance model.
  task automatic step(input logic rst, input logic ordy);
    logic [N-1:0] vm;
    logic [N-1:0] exp_rdy;
    int   g;
    logic acc;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      vm[i] = pend[i];
      in_data[i*W +: W] = pdat[i];
    end
    in_valid  = vm;
    reset     = rst;
    out_ready = ordy;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (g < 0 && vm[c]) g = c;
    end
    acc = !rst && (g >= 0) && (!m_full || ordy);
    exp_rdy = '0;
    if (acc) exp_rdy[g] = 1'b1;
    if (rst) sb.delete();
    else if (acc) begin
      e.d = pdat[g];
      e.c = SELW'(g);
      sb.push_back(e);
    end
    @(negedge clk);
    seen_rdy = in_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_full));
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0;
      m_ptr  = N - 1;
    end else if (acc) begin
      m_full  = 1'b1;
      m_ptr   = g;
      pend[g] = 1'b0;
    end else if (ordy) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  // Monitor: a word is handed over on any non-reset cycle with valid & ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got %0h chan %0d expected none", out_data, out_chan);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_chan", 64'(out_chan), 64'(e.c));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pdat[i] = '0;
    end
    reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;

    // 1: reset then idle
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_chan", 64'(out_chan), 64'h0);
    chk("rst_in_ready", 64'(seen_rdy), 64'h0);

    // 2: all valid, rotation 0,1,2,3,0,...
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        pend[i] = 1'b1;
        pdat[i] = 32'hA0 + W'(i);
      end
      step(1'b0, 1'b1);
      chk("rotate_rdy", 64'(seen_rdy), 64'(1) << (c % 4));
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    step(1'b0, 1'b1);

    // 3: single accept, then stall
    pend[2] = 1'b1; pdat[2] = 32'hDEAD_BEEF;
    step(1'b0, 1'b0);
    chk("ch2_rdy", 64'(seen_rdy), 64'h4);
    step(1'b0, 1'b0);
    chk("stall_rdy", 64'(seen_rdy), 64'h0);
    chk("stall_data", 64'(out_data), 64'hDEAD_BEEF);
    chk("stall_chan", 64'(out_chan), 64'h2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("drained", 64'(out_valid), 64'h0);

    // 4: grant ch3, then ch3+ch1 valid -> ch1 (wrap) then ch3
    pend[3] = 1'b1; pdat[3] = 32'h3333_0001;
    step(1'b0, 1'b1);
    chk("ch3_rdy", 64'(seen_rdy), 64'h8);
    pend[3] = 1'b1; pdat[3] = 32'h3333_0002;
    pend[1] = 1'b1; pdat[1] = 32'h1111_0001;
    step(1'b0, 1'b1);
    chk("wrap_ch1", 64'(seen_rdy), 64'h2);
    step(1'b0, 1'b1);
    chk("then_ch3", 64'(seen_rdy), 64'h8);

    // 5: drain and accept in the same cycle
    pend[0] = 1'b1; pdat[0] = 32'h0F0F_5555;
    step(1'b0, 1'b1);
    chk("refill_rdy", 64'(seen_rdy), 64'h1);
    chk("refill_valid", 64'(out_valid), 64'h1);
    chk("refill_data", 64'(out_data), 64'h0F0F_5555);

    // 6: reset while holding a ch1 word
    pend[1] = 1'b1; pdat[1] = 32'h1111_0002;
    step(1'b0, 1'b1);
    chk("hold_ch1", 64'(out_chan), 64'h1);
    pend[2] = 1'b1; pdat[2] = 32'h2222_0001;
    pend[3] = 1'b1; pdat[3] = 32'h3333_0003;
    step(1'b1, 1'b0);
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_chan", 64'(out_chan), 64'h0);
    step(1'b0, 1'b1);
    chk("post_rst_rdy", 64'(seen_rdy), 64'h4);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45) begin
          pend[i] = 1'b1;
          pdat[i] = $urandom;
        end
      end
      step($urandom_range(0, 149) == 0, $urandom_range(0, 99) < 65);
    end

    // Drain everything and confirm the scoreboard empties
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1);
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
